float_to_fixed_offset_pipe: RTL and testbench

- Pipelined IEEE-754 single-precision to signed fixed-point converter with a built-in offset subtraction and saturation. It is the front end of the cosine CORDIC datapath: it turns the float operand into the fixed-point angle/argument the CORDIC core consumes.
- Generalised successor of the combinational float-to-fixed and subtract-128 pair. It adds parametrised Q format, a parametrised offset, a rounding mode, saturation with a flag, and a Nios custom-instruction start/done handshake.

---
 rtl/float_fixed_pkg.sv | 37 +++
 rtl/fixed_sat_sub.sv | 36 +++
 rtl/float_to_fixed_offset_pipe.sv | 251 +++++++++++++++++++++++++
 tb/tb_float_to_fixed_offset_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/float_fixed_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : float_fixed_pkg
//  Description : Shared IEEE-754 single-precision field constants, operand
//                class encoding, rounding-mode codes and fixed-point width
//                derivation used by the float-to-fixed front end and the
//                CORDIC datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package float_fixed_pkg;

    // IEEE-754 single-precision layout
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;
    localparam int SIG_W    = MAN_W + 1;          // significand incl. hidden bit
    localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

    // Operand classification
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,                          // zero or denormal (flushed)
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_t;

    // Rounding modes
    localparam logic RND_TRUNC = 1'b0;            // toward zero
    localparam logic RND_RNE   = 1'b1;            // nearest, ties to even

    // Signed fixed-point width: sign + integer + fraction bits
    function automatic int fixed_width(input int int_w, input int frac_w);
        return int_w + frac_w + 1;
    endfunction

endpackage : float_fixed_pkg
`default_nettype wire

// File: rtl/fixed_sat_sub.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_sat_sub
//  Description : W-bit two's-complement subtract (a - b) with saturation to
//                the W-bit range. sat is high when the exact difference did
//                not fit and the output was clamped.
//  Revision    : 1.0 - initial release
// ============================================================================
module fixed_sat_sub #(
    parameter int W = 22
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         sat
);

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    // One guard bit makes the exact difference representable
    logic [W:0] w_wide;
    assign w_wide = {a[W-1], a} - {b[W-1], b};

    // Clamp when the two top bits disagree (result left the W-bit range)
    always_comb begin
        sat  = 1'b0;
        diff = w_wide[W-1:0];
        if (w_wide[W] != w_wide[W-1]) begin
            sat  = 1'b1;
            diff = w_wide[W] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule : fixed_sat_sub
`default_nettype wire

// File: rtl/float_to_fixed_offset_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : float_to_fixed_offset_pipe
//  Description : Pipelined IEEE-754 single to signed Q(INT_W.FRAC_W) fixed
//                converter with OFFSET subtraction and saturation. Front end
//                of the cosine CORDIC datapath, driven through a custom-
//                instruction start/done handshake gated by clk_en.
//                Ranks: S1 unpack, S2 align, S3 round/sign, then the output
//                rank applies the offset and raises done.
//  Revision    : 1.0 - initial release
// ============================================================================
module float_to_fixed_offset_pipe
    import float_fixed_pkg::*;
#(
    parameter int INT_W  = 8,
    parameter int FRAC_W = 13,
    parameter int OFFSET = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic        round_mode,
    output logic [31:0] result,
    output logic        done,
    output logic        ovf
);

    localparam int W     = fixed_width(INT_W, FRAC_W);
    localparam int MAG_W = W - 1;

    // Alignment shift s = e - SHIFT_BIAS; a left shift of SHIFT_OVF_AT or
    // more puts the hidden bit at or above the sign position.
    localparam int SHIFT_BIAS   = EXP_BIAS + MAN_W - FRAC_W;
    localparam int SHIFT_OVF_AT = MAG_W - MAN_W;

    // Right shifts beyond RSH_MAX all give magnitude 0 with sticky set, so
    // the shifter only needs RSH_MAX extra low bits to capture guard/sticky.
    localparam int RSH_MAX = SIG_W + 3;
    localparam int EXT_W   = SIG_W + RSH_MAX;

    localparam logic [W-1:0] SAT_MAX    = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN    = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] OFFSET_FIX = W'(OFFSET) << FRAC_W;

    if (W > 32) begin : g_width_check
        $error("float_to_fixed_offset_pipe: INT_W+FRAC_W+1 must not exceed 32");
    end

    // ------------------------------------------------------------------
    // S1: unpack
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_frac;
    fp_class_t        w_cls;
    logic [SIG_W-1:0] w_sig;

    assign w_exp  = dataa[EXP_W+MAN_W-1:MAN_W];
    assign w_frac = dataa[MAN_W-1:0];

    // Classify operand; only normals carry a significand forward
    always_comb begin
        w_cls = CLS_NORM;
        w_sig = {1'b1, w_frac};
        if (w_exp == '0) begin
            w_cls = CLS_ZERO;
            w_sig = '0;
        end else if (w_exp == EXP_ALL_ONES) begin
            w_cls = (w_frac == '0) ? CLS_INF : CLS_NAN;
            w_sig = '0;
        end
    end

    logic             r1_valid;
    logic             r1_sign;
    logic [EXP_W-1:0] r1_exp;
    logic [SIG_W-1:0] r1_sig;
    logic             r1_rnd;
    fp_class_t        r1_cls;

    // S1 register: capture unpacked fields when start is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_exp   <= '0;
            r1_sig   <= '0;
            r1_rnd   <= RND_TRUNC;
            r1_cls   <= CLS_ZERO;
        end else if (clk_en) begin
            r1_valid <= start;
            r1_sign  <= dataa[31];
            r1_exp   <= w_exp;
            r1_sig   <= w_sig;
            r1_rnd   <= round_mode;
            r1_cls   <= w_cls;
        end
    end

    // ------------------------------------------------------------------
    // S2: align
    // ------------------------------------------------------------------
    logic signed [31:0] w_shift;
    logic [5:0]         w_lamt;
    logic [4:0]         w_ramt;
    logic [MAG_W-1:0]   w_left;
    logic [EXT_W-1:0]   w_ext;

    assign w_shift = $signed({24'd0, r1_exp}) - SHIFT_BIAS;
    assign w_lamt  = 6'(w_shift);
    assign w_ramt  = (w_shift < -RSH_MAX) ? 5'(RSH_MAX) : 5'(-w_shift);
    assign w_left  = MAG_W'(r1_sig) << w_lamt;
    assign w_ext   = {r1_sig, {RSH_MAX{1'b0}}} >> w_ramt;

    logic [MAG_W-1:0] w_mag;
    logic             w_guard;
    logic             w_sticky;
    logic             w_big;
    logic             w_nan;

    // Select shift direction, detect magnitude overflow and special classes
    always_comb begin
        w_mag    = '0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        w_big    = 1'b0;
        w_nan    = 1'b0;
        case (r1_cls)
            CLS_NORM: begin
                if (w_shift >= SHIFT_OVF_AT) begin
                    w_big = 1'b1;
                end else if (w_shift >= 0) begin
                    w_mag = w_left;
                end else begin
                    w_mag    = MAG_W'(w_ext[EXT_W-1:RSH_MAX]);
                    w_guard  = w_ext[RSH_MAX-1];
                    w_sticky = |w_ext[RSH_MAX-2:0];
                end
            end
            CLS_INF:  w_big = 1'b1;
            CLS_NAN:  w_nan = 1'b1;
            default:  ;                           // zero/denormal: value 0
        endcase
    end

    logic             r2_valid;
    logic             r2_sign;
    logic [MAG_W-1:0] r2_mag;
    logic             r2_guard;
    logic             r2_sticky;
    logic             r2_big;
    logic             r2_nan;
    logic             r2_rnd;

    // S2 register: aligned magnitude with rounding context
    always_ff @(posedge clk) begin
        if (reset) begin
            r2_valid  <= 1'b0;
            r2_sign   <= 1'b0;
            r2_mag    <= '0;
            r2_guard  <= 1'b0;
            r2_sticky <= 1'b0;
            r2_big    <= 1'b0;
            r2_nan    <= 1'b0;
            r2_rnd    <= RND_TRUNC;
        end else if (clk_en) begin
            r2_valid  <= r1_valid;
            r2_sign   <= r1_sign;
            r2_mag    <= w_mag;
            r2_guard  <= w_guard;
            r2_sticky <= w_sticky;
            r2_big    <= w_big;
            r2_nan    <= w_nan;
            r2_rnd    <= r1_rnd;
        end
    end

    // ------------------------------------------------------------------
    // S3: round, apply sign, saturate the conversion
    // ------------------------------------------------------------------
    logic         w_inc;
    logic [W-1:0] w_rounded;
    logic         w_conv_sat;
    logic [W-1:0] w_conv;

    // Round-to-nearest-even increments on guard when sticky or LSB is set
    assign w_inc      = (r2_rnd == RND_RNE) & r2_guard & (r2_sticky | r2_mag[0]);
    assign w_rounded  = {1'b0, r2_mag} + W'(w_inc);
    assign w_conv_sat = r2_big | w_rounded[W-1];

    // Negative zero collapses to zero through the two's-complement negate
    always_comb begin
        w_conv = r2_sign ? (-w_rounded) : w_rounded;
        if (w_conv_sat) begin
            w_conv = r2_sign ? SAT_MIN : SAT_MAX;
        end
    end

    logic         r3_valid;
    logic [W-1:0] r3_value;
    logic         r3_sat;
    logic         r3_nan;

    // S3 register: signed, saturated conversion result
    always_ff @(posedge clk) begin
        if (reset) begin
            r3_valid <= 1'b0;
            r3_value <= '0;
            r3_sat   <= 1'b0;
            r3_nan   <= 1'b0;
        end else if (clk_en) begin
            r3_valid <= r2_valid;
            r3_value <= w_conv;
            r3_sat   <= w_conv_sat;
            r3_nan   <= r2_nan;
        end
    end

    // ------------------------------------------------------------------
    // Output rank: subtract the scaled offset and saturate again
    // ------------------------------------------------------------------
    logic [W-1:0] w_diff;
    logic         w_sub_sat;

    fixed_sat_sub #(
        .W    (W)
    ) u_offset_sub (
        .a    (r3_value),
        .b    (OFFSET_FIX),
        .diff (w_diff),
        .sat  (w_sub_sat)
    );

    // Output register: result and ovf change only for a valid operation
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            done   <= 1'b0;
            ovf    <= 1'b0;
        end else if (clk_en) begin
            done <= r3_valid;
            if (r3_valid) begin
                result <= 32'(signed'(w_diff));
                ovf    <= r3_sat | w_sub_sat | r3_nan;
            end
        end
    end

endmodule : float_to_fixed_offset_pipe
`default_nettype wire

// File: tb/tb_float_to_fixed_offset_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_float_to_fixed_offset_pipe
//  Description : Scoreboard bench. One stimulus stream drives a default
//                instance (OFFSET=128) and an OFFSET=0 instance; each vector
//                carries hand-computed results for both. A monitor pops the
//                scoreboard on every enabled edge where a result is due.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_float_to_fixed_offset_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic        round_mode;
    logic [31:0] result_d, result_z;
    logic        done_d, done_z;
    logic        ovf_d, ovf_z;

    always #5 clk = ~clk;

    float_to_fixed_offset_pipe #(
        .INT_W (8), .FRAC_W (13), .OFFSET (128)
    ) u_dut_def (
        .clk (clk), .reset (reset), .clk_en (clk_en), .start (start),
        .dataa (dataa), .round_mode (round_mode),
        .result (result_d), .done (done_d), .ovf (ovf_d)
    );

    float_to_fixed_offset_pipe #(
        .INT_W (8), .FRAC_W (13), .OFFSET (0)
    ) u_dut_zero (
        .clk (clk), .reset (reset), .clk_en (clk_en), .start (start),
        .dataa (dataa), .round_mode (round_mode),
        .result (result_z), .done (done_z), .ovf (ovf_z)
    );

    typedef struct {
        logic [31:0] dataa;
        logic        rnd;
        logic [31:0] res_z;
        logic        ovf_z;
        logic [31:0] res_d;
        logic        ovf_d;
    } vec_t;

    typedef struct {
        logic [31:0] res_z;
        logic        ovf_z;
        logic [31:0] res_d;
        logic        ovf_d;
        int unsigned edge_n;
    } exp_t;

    localparam int NV = 20;
    vec_t        vecs [NV];
    exp_t        sb [$];
    int unsigned en_edges = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Expected outputs held while clk_en is low
    logic        last_done = 1'b0;
    logic [31:0] last_res_d = '0, last_res_z = '0;
    logic        last_ovf_d = 1'b0, last_ovf_z = 1'b0;
    logic        since_reset = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (enabled edge %0d)", name, act, exp, en_edges);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic r,
                                input logic [31:0] rz, input logic oz,
                                input logic [31:0] rd, input logic od);
        vec_t v;
        v.dataa = a; v.rnd = r; v.res_z = rz; v.ovf_z = oz; v.res_d = rd; v.ovf_d = od;
        return v;
    endfunction

    task automatic drive(input int i);
        exp_t e;
        start      = 1'b1;
        dataa      = vecs[i].dataa;
        round_mode = vecs[i].rnd;
        e.res_z  = vecs[i].res_z;
        e.ovf_z  = vecs[i].ovf_z;
        e.res_d  = vecs[i].res_d;
        e.ovf_d  = vecs[i].ovf_d;
        e.edge_n = en_edges + 1;
        sb.push_back(e);
    endtask

    task automatic issue(input int i);
        @(negedge clk);
        drive(i);
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && sb.size() > 0; c++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d results never arrived, expected 0 outstanding", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: sample outputs 1 time unit after each rising edge
    always @(posedge clk) begin
        logic en_q, rst_q, due;
        exp_t e;
        en_q  = clk_en;
        rst_q = reset;
        #1;
        if (rst_q) begin
            sb.delete();
            chk("reset_done_d", {31'd0, done_d}, 32'd0);
            chk("reset_done_z", {31'd0, done_z}, 32'd0);
            chk("reset_result_d", result_d, 32'd0);
            chk("reset_ovf_d", {31'd0, ovf_d}, 32'd0);
            last_done   = 1'b0;
            last_res_d  = '0;
            last_res_z  = '0;
            last_ovf_d  = 1'b0;
            last_ovf_z  = 1'b0;
            since_reset = 1'b1;
        end else if (en_q) begin
            en_edges++;
            due = (sb.size() > 0) && (sb[0].edge_n + 3 == en_edges);
            chk("done_d", {31'd0, done_d}, {31'd0, due});
            chk("done_z", {31'd0, done_z}, {31'd0, due});
            if (due) begin
                e = sb.pop_front();
                chk("result_d", result_d, e.res_d);
                chk("ovf_d", {31'd0, ovf_d}, {31'd0, e.ovf_d});
                chk("result_z", result_z, e.res_z);
                chk("ovf_z", {31'd0, ovf_z}, {31'd0, e.ovf_z});
                last_res_d  = e.res_d;
                last_res_z  = e.res_z;
                last_ovf_d  = e.ovf_d;
                last_ovf_z  = e.ovf_z;
                since_reset = 1'b0;
            end else if (since_reset) begin
                chk("post_reset_result_d", result_d, 32'd0);
            end
            last_done = due;
        end else begin
            chk("hold_done_d", {31'd0, done_d}, {31'd0, last_done});
            if (last_done) begin
                chk("hold_result_d", result_d, last_res_d);
                chk("hold_result_z", result_z, last_res_z);
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //              dataa         rnd   OFFSET=0 res  ovf   OFFSET=128 res  ovf
        vecs[0]  = mk(32'h41C80000, 1'b0, 32'h00032000, 1'b0, 32'hFFF32000, 1'b0); // 25.0
        vecs[1]  = mk(32'h437F0000, 1'b0, 32'h001FE000, 1'b0, 32'h000FE000, 1'b0); // 255.0
        vecs[2]  = mk(32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'hFFF00000, 1'b0); // +0.0
        vecs[3]  = mk(32'h43960000, 1'b0, 32'h001FFFFF, 1'b1, 32'h000FFFFF, 1'b1); // 300.0
        vecs[4]  = mk(32'hC3960000, 1'b0, 32'hFFE00000, 1'b1, 32'hFFE00000, 1'b1); // -300.0
        vecs[5]  = mk(32'h7F800000, 1'b0, 32'h001FFFFF, 1'b1, 32'h000FFFFF, 1'b1); // +inf
        vecs[6]  = mk(32'h7FC00000, 1'b0, 32'h00000000, 1'b1, 32'hFFF00000, 1'b1); // NaN
        vecs[7]  = mk(32'hBF800000, 1'b0, 32'hFFFFE000, 1'b0, 32'hFFEFE000, 1'b0); // -1.0
        vecs[8]  = mk(32'h39400000, 1'b1, 32'h00000002, 1'b0, 32'hFFF00002, 1'b0); // 1.5 LSB RNE
        vecs[9]  = mk(32'h39400000, 1'b0, 32'h00000001, 1'b0, 32'hFFF00001, 1'b0); // 1.5 LSB trunc
        vecs[10] = mk(32'hB9400000, 1'b1, 32'hFFFFFFFE, 1'b0, 32'hFFEFFFFE, 1'b0); // -1.5 LSB RNE
        vecs[11] = mk(32'h38800000, 1'b1, 32'h00000000, 1'b0, 32'hFFF00000, 1'b0); // 0.5 LSB tie->0
        vecs[12] = mk(32'h39A00000, 1'b1, 32'h00000002, 1'b0, 32'hFFF00002, 1'b0); // 2.5 LSB tie->2
        vecs[13] = mk(32'h437FFFFF, 1'b1, 32'h001FFFFF, 1'b1, 32'h000FFFFF, 1'b1); // round carry ovf
        vecs[14] = mk(32'h437FFFFF, 1'b0, 32'h001FFFFF, 1'b0, 32'h000FFFFF, 1'b0); // trunc, max fit
        vecs[15] = mk(32'hC37FFFFF, 1'b1, 32'hFFE00000, 1'b1, 32'hFFE00000, 1'b1); // neg carry ovf
        vecs[16] = mk(32'h80000000, 1'b0, 32'h00000000, 1'b0, 32'hFFF00000, 1'b0); // -0.0
        vecs[17] = mk(32'h00000001, 1'b1, 32'h00000000, 1'b0, 32'hFFF00000, 1'b0); // denormal
        vecs[18] = mk(32'hC37F0000, 1'b0, 32'hFFE02000, 1'b0, 32'hFFE00000, 1'b1); // -255: sub sat
        vecs[19] = mk(32'h00800000, 1'b1, 32'h00000000, 1'b0, 32'hFFF00000, 1'b0); // tiny normal

        reset      = 1'b1;
        clk_en     = 1'b1;
        start      = 1'b0;
        dataa      = '0;
        round_mode = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Single operation: latency of exactly 3 enabled edges
        issue(0);
        idle();
        drain();

        // Back-to-back stream with a 2-cycle clk_en freeze mid-flight
        issue(2);
        issue(0);
        issue(1);
        for (int i = 3; i < NV; i++) begin
            if (i == 6) begin
                @(negedge clk);
                start  = 1'b0;
                clk_en = 1'b0;
                @(negedge clk);
                @(negedge clk);
                clk_en = 1'b1;
                drive(i);
            end else begin
                issue(i);
            end
        end
        idle();
        drain();

        // Reset with two operations in flight: both must be discarded
        issue(0);
        issue(1);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        issue(1);
        idle();
        drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_float_to_fixed_offset_pipe
`default_nettype wire
